// File: rtl/beam_pkg.sv
// Shared types and arithmetic helpers for the beam expansion datapath:
// complex sample layout and the round-half-up / saturate step.
package beam_pkg;

  localparam int IQ_W      = 16;
  localparam int PROD_W    = 33;
  localparam int EXT_W     = PROD_W + 2;
  localparam int SHIFT_DEF = 15;

  typedef struct packed {
    logic signed [IQ_W-1:0] re;
    logic signed [IQ_W-1:0] im;
  } cplx_t;

  // Round half-up at bit 'shift', then clamp to a signed 'width'-bit range.
  function automatic logic signed [PROD_W-1:0] rnd_sat(
    input logic signed [PROD_W-1:0] prod,
    input int                       shift,
    input int                       width
  );
    logic signed [EXT_W-1:0] v_one;
    logic signed [EXT_W-1:0] v_ext;
    logic signed [EXT_W-1:0] v_rnd;
    logic signed [EXT_W-1:0] v_max;
    logic signed [EXT_W-1:0] v_min;
    v_one = EXT_W'(1);
    v_ext = EXT_W'(prod);
    if (shift > 0) begin
      v_rnd = (v_ext + (v_one <<< (shift - 1))) >>> shift;
    end else begin
      v_rnd = v_ext;
    end
    v_max = (v_one <<< (width - 1)) - v_one;
    v_min = -(v_one <<< (width - 1));
    if (v_rnd > v_max) begin
      rnd_sat = PROD_W'(v_max);
    end else if (v_rnd < v_min) begin
      rnd_sat = PROD_W'(v_min);
    end else begin
      rnd_sat = PROD_W'(v_rnd);
    end
  endfunction

endpackage

// File: rtl/beam_expand_if.sv
// Streaming bus of beam_expand: one beam IQ sample in, ANT antenna samples out.
interface beam_expand_if #(
  parameter int ANT = 32,
  parameter int IW  = 32,
  parameter int OW  = 32
);
  logic [IW-1:0]      i_beam_data;
  logic               i_bvalid;
  logic               i_sop;
  logic [ANT*OW-1:0]  o_ants_data;
  logic               o_avalid;
  logic               o_sop;

  modport master (
    output i_beam_data, i_bvalid, i_sop,
    input  o_ants_data, o_avalid, o_sop
  );

  modport slave (
    input  i_beam_data, i_bvalid, i_sop,
    output o_ants_data, o_avalid, o_sop
  );
endinterface

// File: rtl/cmplx_mult_rnd.sv
// One antenna lane: complex multiply, add/sub, then round and saturate,
// each in its own register stage.
module cmplx_mult_rnd
  import beam_pkg::*;
#(
  parameter int OW    = 32,
  parameter int SHIFT = SHIFT_DEF
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  cplx_t         i_a,
  input  cplx_t         i_b,
  output logic [OW-1:0] o_y
);
  localparam int HW = OW / 2;
  localparam int MW = 2 * IQ_W;

  logic signed [MW-1:0]     r_p_rr, r_p_ii, r_p_ri, r_p_ir;
  logic signed [PROD_W-1:0] r_re, r_im;
  logic signed [HW-1:0]     w_re_sat, w_im_sat;

  assign w_re_sat = HW'(rnd_sat(r_re, SHIFT, HW));
  assign w_im_sat = HW'(rnd_sat(r_im, SHIFT, HW));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_p_rr <= '0;
      r_p_ii <= '0;
      r_p_ri <= '0;
      r_p_ir <= '0;
      r_re   <= '0;
      r_im   <= '0;
      o_y    <= '0;
    end else begin
      r_p_rr <= MW'(i_a.re) * MW'(i_b.re);
      r_p_ii <= MW'(i_a.im) * MW'(i_b.im);
      r_p_ri <= MW'(i_a.re) * MW'(i_b.im);
      r_p_ir <= MW'(i_a.im) * MW'(i_b.re);
      r_re   <= PROD_W'(r_p_rr) - PROD_W'(r_p_ii);
      r_im   <= PROD_W'(r_p_ri) + PROD_W'(r_p_ir);
      o_y    <= {w_re_sat, w_im_sat};
    end
  end
endmodule

// File: rtl/beam_expand.sv
// Per-antenna complex precoder: broadcasts one beam sample to ANT lanes, each
// scaled by its code word from a double-buffered bank swapped on symbol start.
module beam_expand
  import beam_pkg::*;
#(
  parameter int ANT   = 32,
  parameter int IW    = 32,
  parameter int OW    = 32,
  parameter int SHIFT = SHIFT_DEF,
  parameter int AW    = $clog2(ANT)
) (
  input  logic            i_clk,
  input  logic            i_reset,
  beam_expand_if.slave    bus,
  input  logic            i_cw_wr,
  input  logic [AW-1:0]   i_cw_addr,
  input  logic [31:0]     i_cw_data,
  input  logic            i_cw_commit,
  output logic            o_cw_ready
);
  logic [ANT-1:0][31:0] r_shadow, r_active, w_shadow_nxt;
  logic                 r_pending;
  logic                 w_swap;
  logic [IW-1:0]        r_beam;
  logic [3:0]           r_vld, r_sop;
  logic [ANT*OW-1:0]    w_ants;

  // A commit arriving with the sop sample swaps immediately, so pending never rises.
  assign w_swap = bus.i_bvalid & bus.i_sop & (r_pending | i_cw_commit);

  // Shadow bank including this cycle's write, so a same-cycle swap picks it up.
  always_comb begin
    w_shadow_nxt = r_shadow;
    if (!r_pending && i_cw_wr) begin
      w_shadow_nxt[i_cw_addr] = i_cw_data;
    end else begin
      w_shadow_nxt = r_shadow;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_shadow  <= '0;
      r_active  <= '0;
      r_pending <= 1'b0;
    end else begin
      r_shadow <= w_shadow_nxt;
      if (w_swap) begin
        r_active  <= w_shadow_nxt;
        r_pending <= 1'b0;
      end else if (i_cw_commit) begin
        r_pending <= 1'b1;
      end else begin
        r_pending <= r_pending;
      end
    end
  end

  // Input register plus valid/sop delay matching the three lane stages.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_beam <= '0;
      r_vld  <= 4'b0000;
      r_sop  <= 4'b0000;
    end else begin
      r_beam <= bus.i_beam_data;
      r_vld  <= {r_vld[2:0], bus.i_bvalid};
      r_sop  <= {r_sop[2:0], bus.i_sop & bus.i_bvalid};
    end
  end

  for (genvar k = 0; k < ANT; k++) begin : g_ant
    cmplx_mult_rnd #(.OW(OW), .SHIFT(SHIFT)) u_cm (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_a     (cplx_t'(r_beam)),
      .i_b     (cplx_t'(r_active[k])),
      .o_y     (w_ants[OW*k +: OW])
    );
  end

  assign bus.o_ants_data = w_ants;
  assign bus.o_avalid    = r_vld[3];
  assign bus.o_sop       = r_sop[3];
  assign o_cw_ready      = ~r_pending;
endmodule

// File: tb/tb_beam_expand.sv
// Scoreboard bench for beam_expand: stimulus pushes expected antenna vectors,
// a negedge monitor pops and compares them when o_avalid is seen.
module tb_beam_expand;
  localparam int ANT = 32;
  localparam int OW  = 32;

  typedef struct {
    logic              sop;
    logic [ANT*OW-1:0] data;
    int                due;
    int                hand_ant;
    logic [31:0]       hand_val;
  } exp_t;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_cw_wr;
  logic [4:0]  i_cw_addr;
  logic [31:0] i_cw_data;
  logic        i_cw_commit;
  logic        o_cw_ready;

  beam_expand_if #(.ANT(ANT), .IW(32), .OW(OW)) bus ();

  beam_expand #(.ANT(ANT), .IW(32), .OW(OW), .SHIFT(15)) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .bus         (bus),
    .i_cw_wr     (i_cw_wr),
    .i_cw_addr   (i_cw_addr),
    .i_cw_data   (i_cw_data),
    .i_cw_commit (i_cw_commit),
    .o_cw_ready  (o_cw_ready)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;
  exp_t q[$];

  logic [31:0] m_shadow [ANT];
  logic [31:0] m_active [ANT];
  logic        m_pending;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference product: 16-bit signed parts, round half-up at bit 15, clamp.
  function automatic logic [31:0] ref_cmul(input logic [31:0] a, input logic [31:0] b);
    longint ar, ai, br, bi, re, im;
    logic [63:0] vr, vi;
    ar = longint'($signed(a[31:16]));
    ai = longint'($signed(a[15:0]));
    br = longint'($signed(b[31:16]));
    bi = longint'($signed(b[15:0]));
    re = (ar * br - ai * bi + 64'sd16384) >>> 15;
    im = (ar * bi + ai * br + 64'sd16384) >>> 15;
    if (re > 64'sd32767) re = 64'sd32767;
    if (re < -64'sd32768) re = -64'sd32768;
    if (im > 64'sd32767) im = 64'sd32767;
    if (im < -64'sd32768) im = -64'sd32768;
    vr = re;
    vi = im;
    return {vr[15:0], vi[15:0]};
  endfunction

  task automatic model_clear();
    for (int k = 0; k < ANT; k++) begin
      m_shadow[k] = 32'h0;
      m_active[k] = 32'h0;
    end
    m_pending = 1'b0;
  endtask

  // One clock of stimulus; the bank model mirrors what the edge will do.
  task automatic step(input logic [31:0] beam, input logic vld, input logic sop,
                      input logic wr, input logic [4:0] addr, input logic [31:0] cwd,
                      input logic commit, input int hand_ant, input logic [31:0] hand_val);
    exp_t e;
    logic swap;
    bus.i_beam_data = beam;
    bus.i_bvalid    = vld;
    bus.i_sop       = sop;
    i_cw_wr         = wr;
    i_cw_addr       = addr;
    i_cw_data       = cwd;
    i_cw_commit     = commit;
    swap = vld & sop & (m_pending | commit);
    if (!m_pending && wr) m_shadow[addr] = cwd;
    if (swap) begin
      for (int k = 0; k < ANT; k++) m_active[k] = m_shadow[k];
      m_pending = 1'b0;
    end else if (commit) begin
      m_pending = 1'b1;
    end
    if (vld) begin
      e.sop = sop;
      for (int k = 0; k < ANT; k++) e.data[OW*k +: OW] = ref_cmul(beam, m_active[k]);
      e.due      = cyc + 4;
      e.hand_ant = hand_ant;
      e.hand_val = hand_val;
      q.push_back(e);
    end
    @(posedge i_clk);
    #1;
    chk("cw_ready", {31'h0, o_cw_ready}, {31'h0, ~m_pending});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, -1, 32'h0);
  endtask

  task automatic wr_cw(input logic [4:0] addr, input logic [31:0] cwd);
    step(32'h0, 1'b0, 1'b0, 1'b1, addr, cwd, 1'b0, -1, 32'h0);
  endtask

  task automatic sample(input logic [31:0] beam, input logic sop, input int ha, input logic [31:0] hv);
    step(beam, 1'b1, sop, 1'b0, 5'd0, 32'h0, 1'b0, ha, hv);
  endtask

  task automatic rst_cycle(input logic [31:0] beam, input logic vld);
    i_reset         = 1'b1;
    bus.i_beam_data = beam;
    bus.i_bvalid    = vld;
    bus.i_sop       = 1'b0;
    i_cw_wr         = 1'b0;
    i_cw_commit     = 1'b0;
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    q.delete();
    model_clear();
    chk("rst_avalid", {31'h0, bus.o_avalid}, 32'h0);
    chk("rst_sop", {31'h0, bus.o_sop}, 32'h0);
    chk("rst_data_zero", {31'h0, (bus.o_ants_data === '0)}, 32'h1);
    chk("rst_cw_ready", {31'h0, o_cw_ready}, 32'h1);
  endtask

  // Monitor: every valid output must match the oldest expectation, on time.
  always @(negedge i_clk) begin
    if (bus.o_avalid === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_avalid", 32'h1, 32'h0);
      end else begin
        exp_t e;
        int bad;
        e = q.pop_front();
        bad = -1;
        for (int k = ANT - 1; k >= 0; k--) begin
          if (bus.o_ants_data[OW*k +: OW] !== e.data[OW*k +: OW]) bad = k;
        end
        chk("latency", cyc, e.due);
        chk("o_sop", {31'h0, bus.o_sop}, {31'h0, e.sop});
        if (bad >= 0) begin
          chk($sformatf("ant%0d_model", bad), bus.o_ants_data[OW*bad +: OW], e.data[OW*bad +: OW]);
        end else begin
          chk("ants_model", 32'h0, 32'h0 | {31'h0, (bad >= 0)});
        end
        if (e.hand_ant >= 0) begin
          chk($sformatf("ant%0d_hand", e.hand_ant), bus.o_ants_data[OW*e.hand_ant +: OW], e.hand_val);
        end
      end
    end else if (bus.o_avalid === 1'b0) begin
      if (bus.o_sop !== 1'b0) chk("sop_without_valid", {31'h0, bus.o_sop}, 32'h0);
    end else begin
      chk("avalid_x", 32'h1, 32'h0);
    end
  end

  initial begin
    model_clear();
    i_cw_addr = 5'd0;
    i_cw_data = 32'h0;
    rst_cycle(32'h0, 1'b0);

    // zero banks give zero output
    sample(32'h1234_5678, 1'b0, 0, 32'h0000_0000);

    // bank swap waits for sop; writes while pending are dropped
    wr_cw(5'd3, 32'h4000_0000);
    step(32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, -1, 32'h0);
    sample(32'h0002_0000, 1'b0, 3, 32'h0000_0000);
    wr_cw(5'd5, 32'h7FFF_0000);
    sample(32'h0002_0000, 1'b1, 3, 32'h0001_0000);
    sample(32'h0002_0000, 1'b0, 5, 32'h0000_0000);

    // unit gain on every antenna
    for (int k = 0; k < ANT; k++) wr_cw(5'(k), 32'h7FFF_0000);
    step(32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, -1, 32'h0);
    idle(2);
    sample(32'h1000_2000, 1'b1, 31, 32'h1000_2000);
    sample(32'h1000_2000, 1'b0, 0, 32'h1000_2000);

    // saturation and rounding boundary, commit together with sop
    wr_cw(5'd0, 32'h8000_8000);
    wr_cw(5'd1, 32'h4000_0000);
    wr_cw(5'd2, 32'h3FFF_0000);
    step(32'h8000_8000, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 0, 32'h0000_7FFF);
    sample(32'h8000_8000, 1'b0, 1, 32'hC000_C000);
    sample(32'h0001_0000, 1'b0, 1, 32'h0001_0000);
    sample(32'h0001_0000, 1'b0, 2, 32'h0000_0000);
    sample(32'hFFFF_0000, 1'b0, 1, 32'h0000_0000);

    // write and commit in one cycle: the write joins the swap
    step(32'h0, 1'b0, 1'b0, 1'b1, 5'd4, 32'h0000_4000, 1'b1, -1, 32'h0);
    sample(32'h0002_0000, 1'b1, 4, 32'h0000_0001);

    // reset in the middle of a continuous stream
    sample(32'h1000_2000, 1'b1, 31, 32'h1000_2000);
    for (int i = 0; i < 5; i++) sample(32'h1000_2000, 1'b0, 7, 32'h1000_2000);
    rst_cycle(32'h1000_2000, 1'b1);
    idle(6);
    sample(32'h1000_2000, 1'b1, 0, 32'h0000_0000);
    sample(32'h1000_2000, 1'b0, 7, 32'h0000_0000);

    idle(8);
    chk("queue_drained", q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
